cache_bus_arbiter: RTL and testbench
====================================

CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

Interface
REQ-001 SHALL have parameter N_RD, default 2, number of cache read channels (index 0 = dcache).
REQ-002 SHALL have parameter LINE_WORDS, default 8, 32-bit words per cache line (power of two, 2..16).
REQ-003 SHALL have parameter ARB_MODE, default 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-004 SHALL have ports: clk  in  1  clock, all state on rising edge.
REQ-005 SHALL have: resetn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have: rd_req_i  in  N_RD  per-channel line-read request, held until its finish pulse.
REQ-007 SHALL have: rd_type_i  in  3*N_RD; rd_addr_i  in  32*N_RD  per-channel type/address.
REQ-008 SHALL have: rd_finish_o  out  N_RD  one-cycle done pulse per channel.
REQ-009 SHALL have: rd_data_o  out  32*LINE_WORDS  assembled line, word k at bits [32k+31:32k].
REQ-010 SHALL have: rd_req_o out 1, rd_type_o out 3, rd_addr_o out 32, rd_rdy_i in 1, ret_valid_i in 1, ret_last_i in 1, ret_data_i in 32  bus read side.
REQ-011 SHALL have: wr_req_i in 1, wr_type_i in 3, wr_addr_i in 32, wr_wstrb_i in 4, wr_data_i in 32*LINE_WORDS, wr_finish_o out 1  dcache write side.
REQ-012 SHALL have: wr_req_o out 1, wr_type_o out 3, wr_addr_o out 32, wr_wstrb_o out 4, wr_data_o out 32*LINE_WORDS, wr_rdy_i in 1, wr_resp_i in 1  bus write side.

Function
REQ-013 Read FSM SHALL have states IDLE, REQ, RECV; grant register gnt (one-hot N_RD) and word counter cnt (log2(LINE_WORDS)+1 bits).
REQ-014 IDLE: if any eligible rd_req_i, SHALL latch winner into gnt, latch its type/address, go REQ next cycle.
REQ-015 Eligible = rd_req_i set and no write hazard (REQ-024).
REQ-016 ARB_MODE 0: lowest eligible index wins; ARB_MODE 1: search starts at index after last granted, wraps N_RD-1 -> 0; pointer reset to N_RD-1 (channel 0 first).
REQ-017 REQ: rd_req_o = 1 with latched type/address; on rd_req_o & rd_rdy_i go RECV, cnt <= 0.
REQ-018 RECV: on ret_valid_i, word cnt written to rd_data_o slot cnt, cnt increments; beats with cnt >= LINE_WORDS SHALL be discarded, no wrap.
REQ-019 RECV: on ret_valid_i & ret_last_i go IDLE; rd_finish_o[granted] SHALL pulse exactly the next cycle (1-cycle latency from last beat); rd_data_o held stable until next grant leaves IDLE.
REQ-020 Early ret_last_i (fewer than LINE_WORDS beats) SHALL still finish; unfilled slots keep zero.
REQ-021 rd_data_o SHALL be cleared to 0 when leaving IDLE on a new grant.
REQ-022 Channel request dropped while granted SHALL not abort the transfer; finish still pulses.
REQ-023 Write FSM SHALL have states WIDLE, WREQ, WRESP: WIDLE latches wr_* on wr_req_i -> WREQ; wr_req_o = 1 in WREQ, on wr_rdy_i -> WRESP; on wr_resp_i -> WIDLE and wr_finish_o pulses next cycle.
REQ-024 Hazard: while write FSM not WIDLE, a read whose address bits [31:log2(LINE_WORDS)+2] equal latched write address SHALL be ineligible; other reads proceed concurrently.
REQ-025 wr_*_o payload SHALL come from latched registers, stable from WREQ until WIDLE.
REQ-026 Simultaneous wr_req_i and hazardous read in same cycle: write latches, read waits.

Reset
REQ-027 On resetn low (asynchronous): FSMs IDLE/WIDLE, gnt = 0, cnt = 0, rd_data_o = 0, all req/finish outputs 0, wr_wstrb_o = 4'hF, other payload outputs 0, RR pointer N_RD-1.
REQ-028 Reset mid-transfer SHALL abort with no finish pulse; bus responses arriving after release while IDLE SHALL be ignored.

Verification
REQ-029 Single read ch1, addr 0x1000_0040, 8 beats 0..7 -> rd_data_o = {7,...,0}, rd_finish_o = 2'b10 one cycle after last beat.
REQ-030 ARB_MODE 1, both channels held 3 transfers -> grants ch0, ch1, ch0; ARB_MODE 0 -> ch0 every time.
REQ-031 Write 0x2000_0000 pending, read ch0 0x2000_0010 -> rd_req_o stays 0 until wr_resp_i; read 0x3000_0000 proceeds concurrently.
REQ-032 ret_last_i on beat 3 -> finish pulse, words 4..7 = 0; 10 beats without last -> words 8,9 discarded.
REQ-033 resetn low during RECV beat 4 -> all outputs at reset values same cycle, no finish pulse.

Source files
------------

// File: rtl/cache_bus_arbiter.sv
// Shares one line-read bus among N_RD cache channels and one write bus with the dcache;
// a read whose line matches a write still in flight is held back until that write completes.
module cache_bus_arbiter #(
    parameter int N_RD       = 2,
    parameter int LINE_WORDS = 8,
    parameter int ARB_MODE   = 0
) (
    input  logic                       clk,
    input  logic                       resetn,

    input  logic [N_RD-1:0]            rd_req_i,
    input  logic [3*N_RD-1:0]          rd_type_i,
    input  logic [32*N_RD-1:0]         rd_addr_i,
    output logic [N_RD-1:0]            rd_finish_o,
    output logic [32*LINE_WORDS-1:0]   rd_data_o,

    output logic                       rd_req_o,
    output logic [2:0]                 rd_type_o,
    output logic [31:0]                rd_addr_o,
    input  logic                       rd_rdy_i,
    input  logic                       ret_valid_i,
    input  logic                       ret_last_i,
    input  logic [31:0]                ret_data_i,

    input  logic                       wr_req_i,
    input  logic [2:0]                 wr_type_i,
    input  logic [31:0]                wr_addr_i,
    input  logic [3:0]                 wr_wstrb_i,
    input  logic [32*LINE_WORDS-1:0]   wr_data_i,
    output logic                       wr_finish_o,

    output logic                       wr_req_o,
    output logic [2:0]                 wr_type_o,
    output logic [31:0]                wr_addr_o,
    output logic [3:0]                 wr_wstrb_o,
    output logic [32*LINE_WORDS-1:0]   wr_data_o,
    input  logic                       wr_rdy_i,
    input  logic                       wr_resp_i
);

    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int CNT_W   = OFF_W + 1;
    localparam int TAG_LSB = OFF_W + 2;
    localparam int TAG_W   = 32 - TAG_LSB;
    localparam int PTR_W   = (N_RD > 1) ? $clog2(N_RD) : 1;
    localparam int LINE_W  = 32 * LINE_WORDS;

    typedef enum logic [1:0] {IDLE, REQ, RECV} rd_state_e;
    typedef enum logic [1:0] {WIDLE, WREQ, WRESP} wr_state_e;

    rd_state_e         rd_state_q, rd_state_d;
    logic [N_RD-1:0]   gnt_q, gnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [2:0]        rd_type_q, rd_type_d;
    logic [31:0]       rd_addr_q, rd_addr_d;
    logic [LINE_W-1:0] rd_data_q, rd_data_d;
    logic              rd_req_q, rd_req_d;
    logic [N_RD-1:0]   rd_finish_q, rd_finish_d;

    wr_state_e         wr_state_q, wr_state_d;
    logic              wr_req_q, wr_req_d;
    logic [2:0]        wr_type_q, wr_type_d;
    logic [31:0]       wr_addr_q, wr_addr_d;
    logic [3:0]        wr_wstrb_q, wr_wstrb_d;
    logic [LINE_W-1:0] wr_data_q, wr_data_d;
    logic              wr_finish_q, wr_finish_d;

    logic [N_RD-1:0]   hazard;
    logic [N_RD-1:0]   eligible;
    logic [PTR_W-1:0]  search_base;
    logic [PTR_W-1:0]  cand_idx;
    logic [PTR_W-1:0]  win_idx;
    logic              win_found;

    function automatic logic [PTR_W-1:0] wrap_index(input logic [PTR_W-1:0] base, input int step);
        int unsigned sum;
        sum = (int'(base) + step) % N_RD;
        return sum[PTR_W-1:0];
    endfunction

    // A write being accepted this very cycle blocks its line too, so the write wins a same-cycle race.
    always_comb begin
        hazard = '0;
        for (int i = 0; i < N_RD; i++) begin
            if (wr_state_q != WIDLE &&
                rd_addr_i[32*i+TAG_LSB +: TAG_W] == wr_addr_q[31:TAG_LSB])
                hazard[i] = 1'b1;
            if (wr_state_q == WIDLE && wr_req_i &&
                rd_addr_i[32*i+TAG_LSB +: TAG_W] == wr_addr_i[31:TAG_LSB])
                hazard[i] = 1'b1;
        end
        eligible = rd_req_i & ~hazard;
    end

    always_comb begin
        search_base = (ARB_MODE == 1) ? rr_ptr_q : PTR_W'(N_RD - 1);
        cand_idx    = '0;
        win_idx     = '0;
        win_found   = 1'b0;
        for (int k = 1; k <= N_RD; k++) begin
            cand_idx = wrap_index(search_base, k);
            if (!win_found && eligible[cand_idx]) begin
                win_idx   = cand_idx;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        rd_state_d  = rd_state_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        rd_type_d   = rd_type_q;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        rd_finish_d = '0;
        case (rd_state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    rd_type_d      = rd_type_i[3*int'(win_idx) +: 3];
                    rd_addr_d      = rd_addr_i[32*int'(win_idx) +: 32];
                    rd_data_d      = '0;
                    rr_ptr_d       = win_idx;
                    rd_state_d     = REQ;
                end
            end
            REQ: begin
                if (rd_rdy_i) begin
                    cnt_d      = '0;
                    rd_state_d = RECV;
                end
            end
            RECV: begin
                if (ret_valid_i) begin
                    for (int k = 0; k < LINE_WORDS; k++) begin
                        if (cnt_q == CNT_W'(k))
                            rd_data_d[32*k +: 32] = ret_data_i;
                    end
                    // Saturate so surplus beats can never wrap back onto word 0.
                    if (cnt_q < CNT_W'(LINE_WORDS))
                        cnt_d = cnt_q + CNT_W'(1);
                    if (ret_last_i) begin
                        rd_finish_d = gnt_q;
                        gnt_d       = '0;
                        rd_state_d  = IDLE;
                    end
                end
            end
            default: rd_state_d = IDLE;
        endcase
        rd_req_d = (rd_state_d == REQ);
    end

    always_comb begin
        wr_state_d  = wr_state_q;
        wr_type_d   = wr_type_q;
        wr_addr_d   = wr_addr_q;
        wr_wstrb_d  = wr_wstrb_q;
        wr_data_d   = wr_data_q;
        wr_finish_d = 1'b0;
        case (wr_state_q)
            WIDLE: begin
                if (wr_req_i) begin
                    wr_type_d  = wr_type_i;
                    wr_addr_d  = wr_addr_i;
                    wr_wstrb_d = wr_wstrb_i;
                    wr_data_d  = wr_data_i;
                    wr_state_d = WREQ;
                end
            end
            WREQ: begin
                if (wr_rdy_i)
                    wr_state_d = WRESP;
            end
            WRESP: begin
                if (wr_resp_i) begin
                    wr_finish_d = 1'b1;
                    wr_state_d  = WIDLE;
                end
            end
            default: wr_state_d = WIDLE;
        endcase
        wr_req_d = (wr_state_d == WREQ);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_state_q  <= IDLE;
            gnt_q       <= '0;
            cnt_q       <= '0;
            rr_ptr_q    <= PTR_W'(N_RD - 1);
            rd_type_q   <= '0;
            rd_addr_q   <= '0;
            rd_data_q   <= '0;
            rd_req_q    <= 1'b0;
            rd_finish_q <= '0;
            wr_state_q  <= WIDLE;
            wr_req_q    <= 1'b0;
            wr_type_q   <= '0;
            wr_addr_q   <= '0;
            wr_wstrb_q  <= 4'hF;
            wr_data_q   <= '0;
            wr_finish_q <= 1'b0;
        end else begin
            rd_state_q  <= rd_state_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            rd_type_q   <= rd_type_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
            rd_req_q    <= rd_req_d;
            rd_finish_q <= rd_finish_d;
            wr_state_q  <= wr_state_d;
            wr_req_q    <= wr_req_d;
            wr_type_q   <= wr_type_d;
            wr_addr_q   <= wr_addr_d;
            wr_wstrb_q  <= wr_wstrb_d;
            wr_data_q   <= wr_data_d;
            wr_finish_q <= wr_finish_d;
        end
    end

    assign rd_req_o    = rd_req_q;
    assign rd_type_o   = rd_type_q;
    assign rd_addr_o   = rd_addr_q;
    assign rd_data_o   = rd_data_q;
    assign rd_finish_o = rd_finish_q;

    assign wr_req_o    = wr_req_q;
    assign wr_type_o   = wr_type_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_wstrb_o  = wr_wstrb_q;
    assign wr_data_o   = wr_data_q;
    assign wr_finish_o = wr_finish_q;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Drives a fixed-priority and a round-robin arbiter with identical stimulus and checks both
// against vector tables, directed corner sequences and a transaction-level reference model.
module tb_cache_bus_arbiter;

    localparam int N_RD   = 2;
    localparam int LW     = 8;
    localparam int LINE_W = 32 * LW;

    typedef struct {
        logic [1:0] req;
        int         nbeats;
        int         exp_fixed;
        int         exp_rr;
    } arb_vec_t;

    logic                clk = 1'b0;
    logic                resetn;
    logic [N_RD-1:0]     rd_req_i;
    logic [3*N_RD-1:0]   rd_type_i;
    logic [32*N_RD-1:0]  rd_addr_i;
    logic                rd_rdy_i, ret_valid_i, ret_last_i;
    logic [31:0]         ret_data_i;
    logic                wr_req_i;
    logic [2:0]          wr_type_i;
    logic [31:0]         wr_addr_i;
    logic [3:0]          wr_wstrb_i;
    logic [LINE_W-1:0]   wr_data_i;
    logic                wr_rdy_i, wr_resp_i;

    logic [N_RD-1:0]     m0_rd_finish_o, m1_rd_finish_o;
    logic [LINE_W-1:0]   m0_rd_data_o, m1_rd_data_o;
    logic                m0_rd_req_o, m1_rd_req_o;
    logic [2:0]          m0_rd_type_o, m1_rd_type_o;
    logic [31:0]         m0_rd_addr_o, m1_rd_addr_o;
    logic                m0_wr_finish_o, m1_wr_finish_o;
    logic                m0_wr_req_o, m1_wr_req_o;
    logic [2:0]          m0_wr_type_o, m1_wr_type_o;
    logic [31:0]         m0_wr_addr_o, m1_wr_addr_o;
    logic [3:0]          m0_wr_wstrb_o, m1_wr_wstrb_o;
    logic [LINE_W-1:0]   m0_wr_data_o, m1_wr_data_o;

    int pass_count  = 0;
    int check_count = 0;

    always #5 clk = ~clk;

    cache_bus_arbiter #(.N_RD(N_RD), .LINE_WORDS(LW), .ARB_MODE(0)) dut_fixed (
        .clk(clk), .resetn(resetn),
        .rd_req_i(rd_req_i), .rd_type_i(rd_type_i), .rd_addr_i(rd_addr_i),
        .rd_finish_o(m0_rd_finish_o), .rd_data_o(m0_rd_data_o),
        .rd_req_o(m0_rd_req_o), .rd_type_o(m0_rd_type_o), .rd_addr_o(m0_rd_addr_o),
        .rd_rdy_i(rd_rdy_i), .ret_valid_i(ret_valid_i), .ret_last_i(ret_last_i), .ret_data_i(ret_data_i),
        .wr_req_i(wr_req_i), .wr_type_i(wr_type_i), .wr_addr_i(wr_addr_i), .wr_wstrb_i(wr_wstrb_i),
        .wr_data_i(wr_data_i), .wr_finish_o(m0_wr_finish_o),
        .wr_req_o(m0_wr_req_o), .wr_type_o(m0_wr_type_o), .wr_addr_o(m0_wr_addr_o),
        .wr_wstrb_o(m0_wr_wstrb_o), .wr_data_o(m0_wr_data_o),
        .wr_rdy_i(wr_rdy_i), .wr_resp_i(wr_resp_i)
    );

    cache_bus_arbiter #(.N_RD(N_RD), .LINE_WORDS(LW), .ARB_MODE(1)) dut_rr (
        .clk(clk), .resetn(resetn),
        .rd_req_i(rd_req_i), .rd_type_i(rd_type_i), .rd_addr_i(rd_addr_i),
        .rd_finish_o(m1_rd_finish_o), .rd_data_o(m1_rd_data_o),
        .rd_req_o(m1_rd_req_o), .rd_type_o(m1_rd_type_o), .rd_addr_o(m1_rd_addr_o),
        .rd_rdy_i(rd_rdy_i), .ret_valid_i(ret_valid_i), .ret_last_i(ret_last_i), .ret_data_i(ret_data_i),
        .wr_req_i(wr_req_i), .wr_type_i(wr_type_i), .wr_addr_i(wr_addr_i), .wr_wstrb_i(wr_wstrb_i),
        .wr_data_i(wr_data_i), .wr_finish_o(m1_wr_finish_o),
        .wr_req_o(m1_wr_req_o), .wr_type_o(m1_wr_type_o), .wr_addr_o(m1_wr_addr_o),
        .wr_wstrb_o(m1_wr_wstrb_o), .wr_data_o(m1_wr_data_o),
        .wr_rdy_i(wr_rdy_i), .wr_resp_i(wr_resp_i)
    );

    task automatic checkOutput(input string name, input logic [LINE_W-1:0] actual,
                               input logic [LINE_W-1:0] expected);
        check_count++;
        if (actual === expected)
            pass_count++;
        else
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [2:0] t0, input logic [2:0] t1);
        rd_req_i  = req;
        rd_addr_i = {a1, a0};
        rd_type_i = {t1, t0};
    endtask

    // Reference arbiter: walk the channels in priority order and take the first requester.
    function automatic int model_pick(input logic [1:0] req, input int mode, input int last);
        int order[$];
        for (int k = 1; k <= N_RD; k++)
            order.push_back(mode == 1 ? (last + k) % N_RD : k - 1);
        foreach (order[i])
            if (req[order[i]]) return order[i];
        return -1;
    endfunction

    task automatic check_reset(input string tag);
        checkOutput({tag, " ctl"}, {m0_rd_req_o, m0_rd_finish_o, m0_wr_req_o, m0_wr_finish_o,
                                    m1_rd_req_o, m1_rd_finish_o, m1_wr_req_o, m1_wr_finish_o}, '0);
        checkOutput({tag, " rd_data"}, m0_rd_data_o | m1_rd_data_o, '0);
        checkOutput({tag, " rd payload"}, {m0_rd_addr_o, m0_rd_type_o, m1_rd_addr_o, m1_rd_type_o}, '0);
        checkOutput({tag, " wr payload"}, {m0_wr_addr_o, m0_wr_type_o, m1_wr_addr_o, m1_wr_type_o}, '0);
        checkOutput({tag, " wr_data"}, m0_wr_data_o | m1_wr_data_o, '0);
        checkOutput({tag, " wstrb"}, {m0_wr_wstrb_o, m1_wr_wstrb_o}, 8'hFF);
    endtask

    // Acts as the bus slave for one read; returns at the edge where the finish pulse is due.
    task automatic serve_read(input int nbeats, input int rdy_delay, input bit rand_data, input bit gaps,
                              output logic [LINE_W-1:0] exp_line,
                              output logic [31:0] addr0, output logic [31:0] addr1,
                              output logic [2:0] type0, output logic [2:0] type1);
        int          waited;
        bit          early;
        logic [31:0] w;
        exp_line = '0;
        addr0 = '0; addr1 = '0; type0 = '0; type1 = '0;
        waited = 0;
        while (!m0_rd_req_o && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!m0_rd_req_o) begin
            checkOutput("rd_req_o wait timeout", 0, 1);
            return;
        end
        addr0 = m0_rd_addr_o; addr1 = m1_rd_addr_o;
        type0 = m0_rd_type_o; type1 = m1_rd_type_o;
        repeat (rdy_delay) @(negedge clk);
        rd_rdy_i = 1'b1;
        @(negedge clk);
        rd_rdy_i = 1'b0;
        early = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                ret_valid_i = 1'b0;
                @(negedge clk);
            end
            if (m0_rd_finish_o != '0 || m1_rd_finish_o != '0) early = 1'b1;
            w = rand_data ? $urandom : 32'(b);
            ret_valid_i = 1'b1;
            ret_data_i  = w;
            ret_last_i  = (b == nbeats - 1);
            if (b < LW) exp_line[32*b +: 32] = w;
            @(negedge clk);
        end
        ret_valid_i = 1'b0;
        ret_last_i  = 1'b0;
        ret_data_i  = '0;
        checkOutput("finish before last beat", early, 0);
    endtask

    task automatic finish_read(input string tag, input int exp0, input int exp1,
                               input logic [LINE_W-1:0] exp_line, input logic [1:0] keep);
        checkOutput({tag, " finish fixed"}, m0_rd_finish_o, 256'(1) << exp0);
        checkOutput({tag, " finish rr"}, m1_rd_finish_o, 256'(1) << exp1);
        checkOutput({tag, " data fixed"}, m0_rd_data_o, exp_line);
        checkOutput({tag, " data rr"}, m1_rd_data_o, exp_line);
        rd_req_i = rd_req_i & keep;
        @(negedge clk);
        checkOutput({tag, " finish pulse width"}, {m0_rd_finish_o, m1_rd_finish_o}, '0);
        checkOutput({tag, " data hold"}, m0_rd_data_o, exp_line);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        arb_vec_t          vecs[8];
        logic [LINE_W-1:0] line, wdata, const_line;
        logic [31:0]       a0, a1, g0, g1, waddr;
        logic [2:0]        t0, t1, gt0, gt1, wtype;
        logic [3:0]        wstrb;
        logic [1:0]        req;
        int                e0, e1, last_rr, waited;
        bit                bad;

        vecs[0] = '{2'b11, 8, 0, 0};
        vecs[1] = '{2'b11, 8, 0, 1};
        vecs[2] = '{2'b11, 8, 0, 0};
        vecs[3] = '{2'b10, 4, 1, 1};
        vecs[4] = '{2'b01, 10, 0, 0};
        vecs[5] = '{2'b11, 1, 0, 1};
        vecs[6] = '{2'b11, 3, 0, 0};
        vecs[7] = '{2'b10, 8, 1, 1};

        resetn = 1'b0;
        rd_req_i = '0; rd_type_i = '0; rd_addr_i = '0;
        rd_rdy_i = 1'b0; ret_valid_i = 1'b0; ret_last_i = 1'b0; ret_data_i = '0;
        wr_req_i = 1'b0; wr_type_i = '0; wr_addr_i = '0; wr_wstrb_i = '0; wr_data_i = '0;
        wr_rdy_i = 1'b0; wr_resp_i = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset held");
        resetn = 1'b1;
        @(negedge clk);
        check_reset("after release");

        // Arbitration vectors: both arbiters see the same requests, ordering differs by mode.
        for (int i = 0; i < 8; i++) begin
            a0 = 32'h4000_0000 + 32'(i) * 32'h100;
            a1 = 32'h5000_0000 + 32'(i) * 32'h100;
            applyStimulus(vecs[i].req, a0, a1, 3'd1, 3'd2);
            serve_read(vecs[i].nbeats, i % 3, 1'b1, 1'b0, line, g0, g1, gt0, gt1);
            checkOutput($sformatf("vec%0d addr fixed", i), g0, vecs[i].exp_fixed == 0 ? a0 : a1);
            checkOutput($sformatf("vec%0d addr rr", i), g1, vecs[i].exp_rr == 0 ? a0 : a1);
            checkOutput($sformatf("vec%0d type fixed", i), gt0, vecs[i].exp_fixed == 0 ? 3'd1 : 3'd2);
            finish_read($sformatf("vec%0d", i), vecs[i].exp_fixed, vecs[i].exp_rr, line, 2'b00);
        end

        // Single full-line read on channel 1 with counting data.
        const_line = 256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000;
        applyStimulus(2'b10, 32'h0, 32'h1000_0040, 3'd0, 3'd4);
        serve_read(8, 0, 1'b0, 1'b0, line, g0, g1, gt0, gt1);
        checkOutput("ch1 line addr", g0, 32'h1000_0040);
        checkOutput("ch1 line type", gt0, 3'd4);
        finish_read("ch1 line", 1, 1, const_line, 2'b00);

        // Short line (last on beat 3) then an overlong burst of 10 beats.
        applyStimulus(2'b01, 32'h1000_0080, 32'h0, 3'd0, 3'd0);
        serve_read(4, 1, 1'b0, 1'b0, line, g0, g1, gt0, gt1);
        finish_read("early last", 0, 0,
                    256'h00000000_00000000_00000000_00000000_00000003_00000002_00000001_00000000, 2'b00);
        applyStimulus(2'b01, 32'h1000_00C0, 32'h0, 3'd0, 3'd0);
        serve_read(10, 0, 1'b0, 1'b0, line, g0, g1, gt0, gt1);
        finish_read("overlong burst", 0, 0, const_line, 2'b00);

        // Write hazard: write and a same-line read arrive together; the write must win.
        wdata = {8{32'hCAFE_0000}};
        wr_req_i = 1'b1; wr_addr_i = 32'h2000_0000; wr_type_i = 3'd5; wr_wstrb_i = 4'h3; wr_data_i = wdata;
        applyStimulus(2'b01, 32'h2000_0010, 32'h0, 3'd1, 3'd0);
        @(negedge clk);
        wr_req_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
        checkOutput("hazard wr_req_o", {m0_wr_req_o, m1_wr_req_o}, 2'b11);
        checkOutput("hazard rd_req_o", {m0_rd_req_o, m1_rd_req_o}, 2'b00);
        checkOutput("hazard wr payload", {m0_wr_addr_o, m0_wr_type_o, m0_wr_wstrb_o},
                    {32'h2000_0000, 3'd5, 4'h3});
        checkOutput("hazard wr data", m0_wr_data_o, wdata);
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (m0_rd_req_o || m1_rd_req_o) bad = 1'b1;
        end
        checkOutput("hazard read held in WREQ", bad, 0);
        wr_rdy_i = 1'b1;
        @(negedge clk);
        wr_rdy_i = 1'b0;
        checkOutput("wr_req_o drop after rdy", m0_wr_req_o, 0);
        checkOutput("wr payload stable", m0_wr_addr_o, 32'h2000_0000);
        applyStimulus(2'b11, 32'h2000_0010, 32'h3000_0000, 3'd1, 3'd2);
        serve_read(8, 0, 1'b1, 1'b0, line, g0, g1, gt0, gt1);
        checkOutput("concurrent read addr", {g0, g1}, {32'h3000_0000, 32'h3000_0000});
        checkOutput("write still pending", {m0_wr_finish_o, m0_wr_req_o}, 2'b00);
        finish_read("concurrent read", 1, 1, line, 2'b01);
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (m0_rd_req_o || m1_rd_req_o) bad = 1'b1;
        end
        checkOutput("hazard read held in WRESP", bad, 0);
        wr_resp_i = 1'b1;
        @(negedge clk);
        wr_resp_i = 1'b0;
        checkOutput("wr_finish pulse", {m0_wr_finish_o, m1_wr_finish_o}, 2'b11);
        checkOutput("rd_req_o still low at wr finish", m0_rd_req_o, 0);
        @(negedge clk);
        checkOutput("wr_finish pulse width", {m0_wr_finish_o, m1_wr_finish_o}, 2'b00);
        serve_read(8, 0, 1'b1, 1'b0, line, g0, g1, gt0, gt1);
        checkOutput("released read addr", g0, 32'h2000_0010);
        finish_read("released read", 0, 0, line, 2'b00);

        // Randomized writes: the bus payload must be the value captured at request time.
        for (int i = 0; i < 8; i++) begin
            waddr = $urandom; wtype = 3'($urandom_range(0, 7)); wstrb = 4'($urandom_range(0, 15));
            for (int k = 0; k < LW; k++) wdata[32*k +: 32] = $urandom;
            wr_req_i = 1'b1; wr_addr_i = waddr; wr_type_i = wtype; wr_wstrb_i = wstrb; wr_data_i = wdata;
            @(negedge clk);
            wr_req_i = 1'b0; wr_addr_i = ~waddr; wr_type_i = ~wtype; wr_wstrb_i = ~wstrb; wr_data_i = ~wdata;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checkOutput($sformatf("wr%0d req", i), {m0_wr_req_o, m1_wr_req_o}, 2'b11);
            checkOutput($sformatf("wr%0d payload", i), {m0_wr_addr_o, m0_wr_type_o, m0_wr_wstrb_o},
                        {waddr, wtype, wstrb});
            checkOutput($sformatf("wr%0d data", i), m0_wr_data_o, wdata);
            wr_rdy_i = 1'b1;
            @(negedge clk);
            wr_rdy_i = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checkOutput($sformatf("wr%0d wait resp", i), {m0_wr_req_o, m0_wr_finish_o, m0_wr_addr_o},
                        {2'b00, waddr});
            wr_resp_i = 1'b1;
            @(negedge clk);
            wr_resp_i = 1'b0;
            checkOutput($sformatf("wr%0d finish", i), {m0_wr_finish_o, m1_wr_finish_o}, 2'b11);
            @(negedge clk);
            checkOutput($sformatf("wr%0d finish width", i), {m0_wr_finish_o, m1_wr_finish_o}, 2'b00);
        end

        // Randomized reads from a fresh reset, checked against the reference arbiter.
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        last_rr = N_RD - 1;
        for (int i = 0; i < 40; i++) begin
            req = 2'($urandom_range(1, 3));
            a0 = $urandom; a1 = $urandom;
            t0 = 3'($urandom_range(0, 7)); t1 = 3'($urandom_range(0, 7));
            applyStimulus(req, a0, a1, t0, t1);
            e0 = model_pick(req, 0, last_rr);
            e1 = model_pick(req, 1, last_rr);
            last_rr = e1;
            serve_read($urandom_range(1, 10), $urandom_range(0, 3), 1'b1, 1'b1, line, g0, g1, gt0, gt1);
            checkOutput($sformatf("rnd%0d addr fixed", i), g0, e0 == 0 ? a0 : a1);
            checkOutput($sformatf("rnd%0d addr rr", i), g1, e1 == 0 ? a0 : a1);
            checkOutput($sformatf("rnd%0d type", i), {gt0, gt1}, {e0 == 0 ? t0 : t1, e1 == 0 ? t0 : t1});
            finish_read($sformatf("rnd%0d", i), e0, e1, line, 2'b00);
        end

        // Asynchronous reset while the fifth beat is on the bus, then stray responses.
        applyStimulus(2'b01, 32'h6000_0000, 32'h0, 3'd3, 3'd0);
        waited = 0;
        while (!m0_rd_req_o && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("abort read granted", m0_rd_req_o, 1);
        rd_rdy_i = 1'b1;
        @(negedge clk);
        rd_rdy_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            ret_valid_i = 1'b1; ret_data_i = 32'h100 + 32'(b);
            @(negedge clk);
        end
        ret_data_i = 32'h104;
        #1 resetn = 1'b0;
        #1 check_reset("reset in RECV");
        rd_req_i = '0;
        ret_valid_i = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        bad = 1'b0;
        for (int b = 0; b < 3; b++) begin
            ret_valid_i = 1'b1; ret_last_i = 1'b1; ret_data_i = 32'hDEAD_0000 + 32'(b);
            @(negedge clk);
            if (m0_rd_finish_o != '0 || m1_rd_finish_o != '0 || m0_rd_req_o || m0_rd_data_o != '0)
                bad = 1'b1;
        end
        ret_valid_i = 1'b0; ret_last_i = 1'b0; ret_data_i = '0;
        checkOutput("stray beats ignored", bad, 0);
        @(negedge clk);
        check_reset("after abort");

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
